// File: rtl/apb_clint_pkg.sv
// Shared definitions for the CLINT APB completer: register offsets, APB state
// encoding and the byte-strobe merge helper.
package apb_clint_pkg;

    localparam int CLINT_ADDR_W = 16;

    localparam logic [CLINT_ADDR_W-1:0] OFF_MSIP        = 16'h0000;
    localparam logic [CLINT_ADDR_W-1:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [CLINT_ADDR_W-1:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [CLINT_ADDR_W-1:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [CLINT_ADDR_W-1:0] OFF_MTIME_HI    = 16'hBFFC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_clint_if.sv
// APB bus bundle between the system decoder (master) and a completer (slave).
interface apb_clint_if #(
    parameter int ADDR_W = 16
);
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pwstrb;
    logic              pready;
    logic [31:0]       prdata;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cmpl_fsm.sv
// Generic APB completer sequencer: latches the request in SETUP, inserts wait
// states, then raises pready for one cycle together with a commit strobe.
//   state     | meaning
//   ST_IDLE   | no transfer; waiting for psel & ~penable
//   ST_SETUP  | request latched; next edge enters ACCESS
//   ST_ACCESS | wait counter runs down; pready high at terminal count
module apb_cmpl_fsm
    import apb_clint_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [31:0]       i_pwdata,
    input  logic [3:0]        i_pwstrb,
    output logic              o_pready,
    output logic              o_commit,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_wdata,
    output logic [3:0]        o_strb
);

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    apb_state_e        r_state, w_state_next;
    logic [3:0]        r_wcnt, w_wcnt_next;
    logic              r_pready, w_pready_next;
    logic              w_capture;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_strb;

    always_comb begin
        w_state_next  = r_state;
        w_wcnt_next   = r_wcnt;
        w_pready_next = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_psel && !i_penable) begin
                    w_state_next = ST_SETUP;
                    w_capture    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!i_psel) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next  = ST_ACCESS;
                    w_wcnt_next   = WS_CNT;
                    w_pready_next = (WS_CNT == 4'd0);
                end
            end
            ST_ACCESS: begin
                // a dropped psel before completion aborts with no side effect
                if (!i_psel || r_pready) begin
                    w_state_next = ST_IDLE;
                end else if (r_wcnt != 4'd0) begin
                    w_wcnt_next   = r_wcnt - 4'd1;
                    w_pready_next = (r_wcnt == 4'd1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= 4'd0;
            r_pready <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_strb   <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_wcnt   <= w_wcnt_next;
            r_pready <= w_pready_next;
            if (w_capture) begin
                r_write <= i_pwrite;
                r_addr  <= i_paddr;
                r_wdata <= i_pwdata;
                r_strb  <= i_pwstrb;
            end
        end
    end

    assign o_pready = r_pready;
    assign o_commit = r_pready & i_psel & i_penable;
    assign o_write  = r_write;
    assign o_addr   = r_addr;
    assign o_wdata  = r_wdata;
    assign o_strb   = r_strb;

endmodule

// File: rtl/apb_clint.sv
// CLINT-style machine timer / software interrupt block on APB: mtime, mtimecmp,
// msip, prescaled tick and the registered timer-interrupt comparator.
module apb_clint
    import apb_clint_pkg::*;
#(
    parameter int ADDR_W      = CLINT_ADDR_W,
    parameter int TICK_DIV    = 1,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    apb_clint_if.slave  s_apb,
    output logic [63:0] o_mtime,
    output logic        o_mtimer_int,
    output logic        o_msw_int
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic              w_pready, w_commit, w_write;
    logic [ADDR_W-1:0] w_req_addr, w_word;
    logic [31:0]       w_wdata, w_rdata_sel;
    logic [3:0]        w_strb;
    logic              w_unused_addr;

    logic [63:0]   r_mtime, r_mtimecmp;
    logic          r_msip, r_mtimer_int;
    logic [PW-1:0] r_presc;

    logic          w_tick, w_wr, w_mapped;
    logic          w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_mt_lo, w_sel_mt_hi;
    logic [63:0]   w_mtime_ticked, w_mtime_next, w_cmp_next;
    logic          w_msip_next;

    apb_cmpl_fsm #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_psel    (s_apb.psel),
        .i_penable (s_apb.penable),
        .i_pwrite  (s_apb.pwrite),
        .i_paddr   (s_apb.paddr),
        .i_pwdata  (s_apb.pwdata),
        .i_pwstrb  (s_apb.pwstrb),
        .o_pready  (w_pready),
        .o_commit  (w_commit),
        .o_write   (w_write),
        .o_addr    (w_req_addr),
        .o_wdata   (w_wdata),
        .o_strb    (w_strb)
    );

    // byte lanes within a word are not decoded
    assign w_word        = {w_req_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_addr = ^w_req_addr[1:0];

    assign w_sel_msip   = (w_word == ADDR_W'(OFF_MSIP));
    assign w_sel_cmp_lo = (w_word == ADDR_W'(OFF_MTIMECMP_LO));
    assign w_sel_cmp_hi = (w_word == ADDR_W'(OFF_MTIMECMP_HI));
    assign w_sel_mt_lo  = (w_word == ADDR_W'(OFF_MTIME_LO));
    assign w_sel_mt_hi  = (w_word == ADDR_W'(OFF_MTIME_HI));
    assign w_mapped     = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi | w_sel_mt_lo | w_sel_mt_hi;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_wr   = w_commit & w_write;

    // written bytes override the ticked value; unwritten bytes keep the tick and its carry
    always_comb begin
        w_mtime_ticked = r_mtime + 64'(w_tick);
        w_mtime_next   = w_mtime_ticked;
        w_cmp_next     = r_mtimecmp;
        w_msip_next    = r_msip;
        if (w_wr) begin
            if (w_sel_mt_lo)  w_mtime_next[31:0]  = strb_merge(w_mtime_ticked[31:0],  w_wdata, w_strb);
            if (w_sel_mt_hi)  w_mtime_next[63:32] = strb_merge(w_mtime_ticked[63:32], w_wdata, w_strb);
            if (w_sel_cmp_lo) w_cmp_next[31:0]    = strb_merge(r_mtimecmp[31:0],      w_wdata, w_strb);
            if (w_sel_cmp_hi) w_cmp_next[63:32]   = strb_merge(r_mtimecmp[63:32],     w_wdata, w_strb);
            if (w_sel_msip && w_strb[0]) w_msip_next = w_wdata[0];
        end
    end

    always_comb begin
        w_rdata_sel = 32'd0;
        if (w_sel_msip)   w_rdata_sel = {31'd0, r_msip};
        if (w_sel_cmp_lo) w_rdata_sel = r_mtimecmp[31:0];
        if (w_sel_cmp_hi) w_rdata_sel = r_mtimecmp[63:32];
        if (w_sel_mt_lo)  w_rdata_sel = r_mtime[31:0];
        if (w_sel_mt_hi)  w_rdata_sel = r_mtime[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime      <= 64'd0;
            r_mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip       <= 1'b0;
            r_mtimer_int <= 1'b0;
            r_presc      <= '0;
        end else begin
            r_mtime      <= w_mtime_next;
            r_mtimecmp   <= w_cmp_next;
            r_msip       <= w_msip_next;
            r_mtimer_int <= (w_mtime_next >= w_cmp_next);
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    assign s_apb.pready  = w_pready;
    assign s_apb.prdata  = (w_commit && !w_write) ? w_rdata_sel : 32'd0;
    assign s_apb.pslverr = w_commit & ~w_mapped;

    assign o_mtime      = r_mtime;
    assign o_mtimer_int = r_mtimer_int;
    assign o_msw_int    = r_msip;

endmodule
